sop_eval_filt: RTL and testbench
================================

SOP_EVAL_FILT -- requirements
Module: sop_eval_filt

Interface
REQ-001 Parameter N_IN, default 3, number of Boolean inputs (legal 2..6).
REQ-002 Parameter N_OUT, default 2, number of output channels (legal 1..8).
REQ-003 Parameter STABLE_CYC, default 3, consecutive cycles a new value must persist before it is driven out (legal 1..15).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_vec  input  N_IN  Boolean inputs, in_vec[N_IN-1] is MSB of truth-table index.
REQ-007 cfg_valid  input  1  truth-table write request.
REQ-008 cfg_ready  output  1  write may be accepted this cycle.
REQ-009 cfg_sel  input  max(1,clog2(N_OUT))  channel to program.
REQ-010 cfg_table  input  2**N_IN  truth table; bit i = output value for index i.
REQ-011 out_vec  output  N_OUT  filtered, registered channel outputs.
REQ-012 out_chg  output  N_OUT  one-cycle pulse per channel when out_vec bit changes.
REQ-013 glitch_cnt  output  8  saturating rejected-transition count (present only under SOP_GLITCH_CNT_EN).

Function
REQ-014 in_vec registered into in_q every cycle; raw[k] = table[k][in_q], combinational from registers.
REQ-015 Per channel, counter cnt[k] (4 bits): on each edge with raw[k] != out_vec[k], cnt[k] increments; when cnt[k] == STABLE_CYC-1 at that edge, out_vec[k] toggles, out_chg[k]=1 next cycle, cnt[k] cleared.
REQ-016 Edge with raw[k] == out_vec[k] and cnt[k] != 0: cnt[k] cleared, out unchanged (rejected glitch).
REQ-017 Latency: in_vec change held stable shows on out_vec exactly 1+STABLE_CYC rising edges after first sampled.
REQ-018 Pulse shorter than STABLE_CYC cycles on raw[k] never reaches out_vec[k]; out_chg[k] stays 0.
REQ-019 Write handshake: accepted on edge where cfg_valid && cfg_ready; table[cfg_sel] <= cfg_table; cnt[cfg_sel] cleared.
REQ-020 cfg_ready = 0 in the cycle after an accepted write, 1 otherwise; back-to-back writes need a one-cycle gap.
REQ-021 cfg_valid while cfg_ready=0: no effect; requester holds.
REQ-022 cfg_sel >= N_OUT: handshake completes, no table change.
REQ-023 Write to channel k on same edge cnt[k] would reach threshold: write wins, out_vec[k] held, cnt[k] cleared, no out_chg.
REQ-024 Channels independent; any subset may toggle on one edge.
REQ-025 out_vec, out_chg, cfg_ready are registered outputs (no combinational path from inputs).

Reset
REQ-026 rst on an edge: in_q=0, all tables=0, cnt=0, out_vec=0, out_chg=0, cfg_ready=1, glitch_cnt=0.
REQ-027 rst mid-filter or same edge as accepted write: reset wins, write discarded.
REQ-028 First edge after rst released behaves as normal operation from reset state.

Configuration
REQ-029 SOP_GLITCH_CNT_EN defined: glitch_cnt port exists; increments by number of channels rejecting a glitch (REQ-016) that edge, saturates at 255.
REQ-030 SOP_GLITCH_CNT_EN undefined: port and counter absent; all other behaviour identical.

Verification (N_IN=3, N_OUT=2, STABLE_CYC=3; in_vec = {a,b,c})
REQ-031 Program ch0=0x48, ch1=0xF0 (one gap cycle between writes); sweep in_vec 0..7 holding 6 cycles each -> out_vec[0]=1 only at 3,6; out_vec[1]=1 at 4..7; each change 4 edges after in_vec change with one out_chg pulse.
REQ-032 ch1=0xF0, in_vec 0 -> 4 for 2 cycles then 0 -> out_vec[1] stays 0, out_chg 0, glitch_cnt=1.
REQ-033 cfg_valid held high 3 cycles with cfg_sel=0 -> two writes accepted (cycles 0,2), cfg_ready pattern 1,0,1.
REQ-034 Rewrite ch0 on the edge its cnt reaches 2 -> out_vec[0] unchanged, no out_chg; new table then evaluated with full 3-cycle filter.
REQ-035 Assert rst while cnt[1]=2 and a write pending -> all outputs 0, cfg_ready=1, tables 0 next cycle.
REQ-036 30 one-cycle glitches with macro defined -> glitch_cnt=30; 300 glitches -> 255.

Source files
------------

// File: rtl/sop_eval_filt.sv
// sop_eval_filt: per-channel programmable sum-of-products (truth table)
// evaluator with a stability filter on every output channel.
// Optional feature macro: SOP_GLITCH_CNT_EN adds the glitch_cnt port, a
// saturating count of rejected (too-short) transitions.
module sop_eval_filt #(
  parameter int N_IN       = 3,
  parameter int N_OUT      = 2,
  parameter int STABLE_CYC = 3,
  localparam int SEL_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int TBL_W     = 2 ** N_IN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [TBL_W-1:0] cfg_table,
  output logic [N_OUT-1:0] out_vec,
  output logic [N_OUT-1:0] out_chg
`ifdef SOP_GLITCH_CNT_EN
  ,
  output logic [7:0]       glitch_cnt
`endif
);

  // Counter value at which the next differing edge commits the new value.
  localparam logic [3:0] THR = 4'(STABLE_CYC - 1);

  logic [N_IN-1:0]  in_q_r;
  logic [TBL_W-1:0] tbl_r [N_OUT];
  logic [3:0]       cnt_r [N_OUT];
  logic [N_OUT-1:0] out_vec_r;
  logic [N_OUT-1:0] out_chg_r;
  logic             cfg_ready_r;

  logic             wr_acc_s;
  logic [N_OUT-1:0] raw_s;
  logic [N_OUT-1:0] wr_hit_s;
  logic [N_OUT-1:0] rej_s;

  assign cfg_ready = cfg_ready_r;
  assign out_vec   = out_vec_r;
  assign out_chg   = out_chg_r;

  // Truth-table lookup, write decode and glitch-rejection flags per channel.
  always_comb begin
    wr_acc_s = cfg_valid && cfg_ready_r;
    raw_s    = '0;
    wr_hit_s = '0;
    rej_s    = '0;
    for (int k = 0; k < N_OUT; k++) begin
      raw_s[k]    = tbl_r[k][in_q_r];
      // An out-of-range cfg_sel matches no channel, so the write is dropped.
      wr_hit_s[k] = wr_acc_s && (cfg_sel == SEL_W'(k));
      // A write to the channel takes precedence over any rejection.
      if (!wr_hit_s[k] && (raw_s[k] == out_vec_r[k]) && (cnt_r[k] != 4'd0)) begin
        rej_s[k] = 1'b1;
      end else begin
        rej_s[k] = 1'b0;
      end
    end
  end

  // Input sampling, table writes, stability counters and filtered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q_r      <= '0;
      out_vec_r   <= '0;
      out_chg_r   <= '0;
      cfg_ready_r <= 1'b1;
      for (int k = 0; k < N_OUT; k++) begin
        tbl_r[k] <= '0;
        cnt_r[k] <= 4'd0;
      end
    end else begin
      in_q_r      <= in_vec;
      // One dead cycle after each accepted write.
      cfg_ready_r <= !wr_acc_s;
      out_chg_r   <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        if (wr_hit_s[k]) begin
          // New table restarts the filter; a pending toggle is abandoned.
          tbl_r[k] <= cfg_table;
          cnt_r[k] <= 4'd0;
        end else if (raw_s[k] != out_vec_r[k]) begin
          if (cnt_r[k] == THR) begin
            out_vec_r[k] <= raw_s[k];
            out_chg_r[k] <= 1'b1;
            cnt_r[k]     <= 4'd0;
          end else begin
            cnt_r[k] <= cnt_r[k] + 4'd1;
          end
        end else begin
          cnt_r[k] <= 4'd0;
        end
      end
    end
  end

`ifdef SOP_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_r;
  logic [3:0] rej_num_s;
  logic [8:0] glitch_sum_s;
  logic [7:0] glitch_nxt_s;

  assign glitch_cnt = glitch_cnt_r;

  // Number of channels rejecting a glitch this edge, added with saturation.
  always_comb begin
    rej_num_s = 4'd0;
    for (int k = 0; k < N_OUT; k++) begin
      rej_num_s = rej_num_s + {3'd0, rej_s[k]};
    end
    glitch_sum_s = {1'b0, glitch_cnt_r} + {5'd0, rej_num_s};
    if (glitch_sum_s > 9'd255) begin
      glitch_nxt_s = 8'd255;
    end else begin
      glitch_nxt_s = glitch_sum_s[7:0];
    end
  end

  // Saturating rejected-transition counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt_r <= 8'd0;
    end else begin
      glitch_cnt_r <= glitch_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_sop_eval_filt.sv
// Scoreboard testbench for sop_eval_filt (N_IN=3, N_OUT=2, STABLE_CYC=3).
module tb_sop_eval_filt;

  localparam int N_IN   = 3;
  localparam int N_OUT  = 2;
  localparam int STABLE = 3;

  typedef struct {
    logic [1:0] out_v;
    logic [1:0] chg_v;
    logic       rdy;
    logic [7:0] glt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_vec;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_sel;
  logic [7:0] cfg_table;
  logic [1:0] out_vec;
  logic [1:0] out_chg;
`ifdef SOP_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: what the filter should look like after each edge.
  logic [7:0] tbl_m [N_OUT];
  int         streak_m [N_OUT];
  logic [2:0] inq_m;
  logic [1:0] out_m;
  logic [1:0] chg_m;
  logic       rdy_m;
  int         glt_m;
  exp_t       sb_q [$];

  sop_eval_filt #(.N_IN(N_IN), .N_OUT(N_OUT), .STABLE_CYC(STABLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec    (in_vec),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_table (cfg_table),
    .out_vec   (out_vec),
`ifdef SOP_GLITCH_CNT_EN
    .out_chg   (out_chg),
    .glitch_cnt(glitch_cnt)
`else
    .out_chg   (out_chg)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one rising edge, using the inputs now being driven.
  task automatic model_edge();
    exp_t e;
    logic acc;
    logic raw;
    int   rej;
    if (rst) begin
      inq_m = 3'd0; out_m = 2'd0; chg_m = 2'd0; rdy_m = 1'b1; glt_m = 0;
      for (int k = 0; k < N_OUT; k++) begin
        tbl_m[k] = 8'd0; streak_m[k] = 0;
      end
    end else begin
      acc = cfg_valid && rdy_m;
      chg_m = 2'd0;
      rej = 0;
      for (int k = 0; k < N_OUT; k++) begin
        raw = tbl_m[k][inq_m];
        if (acc && (int'(cfg_sel) == k)) begin
          tbl_m[k] = cfg_table;
          streak_m[k] = 0;
        end else if (raw != out_m[k]) begin
          streak_m[k] = streak_m[k] + 1;
          if (streak_m[k] >= STABLE) begin
            out_m[k] = raw; chg_m[k] = 1'b1; streak_m[k] = 0;
          end
        end else begin
          if (streak_m[k] > 0) rej = rej + 1;
          streak_m[k] = 0;
        end
      end
      glt_m = (glt_m + rej > 255) ? 255 : glt_m + rej;
      inq_m = in_vec;
      rdy_m = !acc;
    end
    e.out_v = out_m; e.chg_v = chg_m; e.rdy = rdy_m; e.glt = 8'(glt_m);
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, record expectation, and return #1 after the edge.
  task automatic step(input logic [2:0] iv, input logic cv, input logic s,
                      input logic [7:0] t, input logic r);
    @(negedge clk);
    in_vec = iv; cfg_valid = cv; cfg_sel = s; cfg_table = t; rst = r;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every edge that had an expectation pushed is compared.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_out_vec", 32'(out_vec), 32'(e.out_v));
      check("sb_out_chg", 32'(out_chg), 32'(e.chg_v));
      check("sb_cfg_ready", 32'(cfg_ready), 32'(e.rdy));
`ifdef SOP_GLITCH_CNT_EN
      check("sb_glitch_cnt", 32'(glitch_cnt), 32'(e.glt));
`endif
    end
  end

  initial begin
    logic [1:0] prev_o, cur_o;
    int hold;
    logic [2:0] riv;
    rst = 1'b1; in_vec = 3'd0; cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_table = 8'd0;

    // Reset state.
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_out_vec", 32'(out_vec), 32'd0);
    check("rst_out_chg", 32'(out_chg), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Program ch0=0x48, ch1=0xF0 with a gap, then sweep in_vec 0..7.
    step(3'd0, 1'b1, 1'b0, 8'h48, 1'b0);
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd0, 1'b1, 1'b1, 8'hF0, 1'b0);
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    prev_o = 2'b00;
    for (int v = 0; v < 8; v++) begin
      cur_o = {(v >= 4) ? 1'b1 : 1'b0, (v == 3 || v == 6) ? 1'b1 : 1'b0};
      for (int j = 1; j <= 6; j++) begin
        step(3'(v), 1'b0, 1'b0, 8'h00, 1'b0);
        check("sweep_out", 32'(out_vec), 32'((j >= 4) ? cur_o : prev_o));
        check("sweep_chg", 32'(out_chg), 32'((j == 4) ? (cur_o ^ prev_o) : 2'b00));
      end
      prev_o = cur_o;
    end

    // Two-cycle pulse on ch1 is rejected.
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(3'd0, 1'b1, 1'b1, 8'hF0, 1'b0);
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd4, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd4, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int j = 0; j < 3; j++) begin
      step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
      check("glitch_out1", 32'(out_vec[1]), 32'd0);
      check("glitch_chg", 32'(out_chg), 32'd0);
    end
`ifdef SOP_GLITCH_CNT_EN
    check("glitch_cnt_1", 32'(glitch_cnt), 32'd1);
`endif

    // Reset while cnt[1]=2 and a write is presented: reset wins.
    step(3'd4, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd4, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd4, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd4, 1'b1, 1'b1, 8'hFF, 1'b1);
    check("rstw_out", 32'(out_vec), 32'd0);
    check("rstw_chg", 32'(out_chg), 32'd0);
    check("rstw_ready", 32'(cfg_ready), 32'd1);
    for (int j = 0; j < 5; j++) begin
      step(3'd7, 1'b0, 1'b0, 8'h00, 1'b0);
      check("rstw_tables_zero", 32'(out_vec), 32'd0);
    end

    // cfg_valid held 3 cycles: accepts on cycles 0 and 2.
    check("hold_ready_c0", 32'(cfg_ready), 32'd1);
    step(3'd1, 1'b1, 1'b0, 8'h01, 1'b0);
    check("hold_ready_c1", 32'(cfg_ready), 32'd0);
    step(3'd1, 1'b1, 1'b0, 8'hFF, 1'b0);
    check("hold_ready_c2", 32'(cfg_ready), 32'd1);
    step(3'd1, 1'b1, 1'b0, 8'h02, 1'b0);
    check("hold_ready_c3", 32'(cfg_ready), 32'd0);
    for (int j = 0; j < 4; j++) step(3'd1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("hold_second_write", 32'(out_vec[0]), 32'd1);

    // Rewrite ch0 on its threshold edge: write wins, full refilter after.
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(3'd0, 1'b1, 1'b0, 8'h48, 1'b0);
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd3, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd3, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd3, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd3, 1'b1, 1'b0, 8'h08, 1'b0);
    check("rw_held_out", 32'(out_vec[0]), 32'd0);
    check("rw_no_chg", 32'(out_chg[0]), 32'd0);
    step(3'd3, 1'b0, 1'b0, 8'h00, 1'b0);
    step(3'd3, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rw_still_held", 32'(out_vec[0]), 32'd0);
    step(3'd3, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rw_refilter_out", 32'(out_vec[0]), 32'd1);
    check("rw_refilter_chg", 32'(out_chg[0]), 32'd1);

    // One-cycle glitches on ch1: 30 then saturate past 255.
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(3'd0, 1'b1, 1'b1, 8'hF0, 1'b0);
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int g = 0; g < 300; g++) begin
      step(3'd4, 1'b0, 1'b0, 8'h00, 1'b0);
      step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
      if (g == 29) begin
        step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef SOP_GLITCH_CNT_EN
        check("glitch_cnt_30", 32'(glitch_cnt), 32'd30);
`endif
      end
    end
    step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("glitch_out_quiet", 32'(out_vec), 32'd0);
`ifdef SOP_GLITCH_CNT_EN
    check("glitch_cnt_sat", 32'(glitch_cnt), 32'd255);
`endif

    // Randomized traffic against the model.
    riv = 3'd0; hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        riv  = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 5);
      end
      hold--;
      step(riv, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           8'($urandom), ($urandom_range(0, 99) == 0));
    end

    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
